// File: rtl/bounce_frame_ctrl.sv
// Per-frame sequencer for the colour-bounce game: erase, update/commit, settle,
// then redraw ball and platforms through a request/done drawer handshake.
module bounce_frame_ctrl #(
  parameter int TOP    = 20,
  parameter int BOTTOM = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [1:0]  lane,
  input  logic        draw_done,
  input  logic [7:0]  curr_ball,
  input  logic [2:0]  color_ball,
  input  logic [11:0] color_plats,
  input  logic [27:0] position_plats,
  input  logic [11:0] score,
  output logic        mem_we,
  output logic [7:0]  prev_ball_nxt,
  output logic [7:0]  curr_ball_nxt,
  output logic [2:0]  color_ball_nxt,
  output logic [11:0] score_nxt,
  output logic        draw_req,
  output logic [1:0]  draw_kind,
  output logic [7:0]  draw_pos,
  output logic [2:0]  draw_color,
  output logic        busy,
  output logic        game_over,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_STOPPED, S_IDLE, S_ERASE, S_UPDATE, S_SETTLE, S_DRAW_BALL, S_DRAW_PLAT, S_OVER
  } state_t;

  localparam logic [7:0] TOP_ROW = 8'(TOP);
  localparam logic [7:0] BOT_ROW = 8'(BOTTOM);

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [1:0]  plat_idx_q, plat_idx_d;
  logic [2:0]  lfsr_q, lfsr_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;
  logic        draw_req_q, draw_req_d;
  logic [1:0]  draw_kind_q, draw_kind_d;
  logic [7:0]  draw_pos_q, draw_pos_d;
  logic [2:0]  draw_color_q, draw_color_d;

  logic        upd_dir, miss, done_ok;

  function automatic logic [2:0] plat_color(input logic [1:0] i);
    case (i)
      2'd0:    plat_color = color_plats[2:0];
      2'd1:    plat_color = color_plats[5:3];
      2'd2:    plat_color = color_plats[8:6];
      default: plat_color = color_plats[11:9];
    endcase
  endfunction

  function automatic logic [7:0] plat_pos(input logic [1:0] i);
    case (i)
      2'd0:    plat_pos = {1'b0, position_plats[6:0]};
      2'd1:    plat_pos = {1'b0, position_plats[13:7]};
      2'd2:    plat_pos = {1'b0, position_plats[20:14]};
      default: plat_pos = {1'b0, position_plats[27:21]};
    endcase
  endfunction

  // Commit values are only meaningful (and only non-zero) during UPDATE.
  always_comb begin
    mem_we         = 1'b0;
    prev_ball_nxt  = '0;
    curr_ball_nxt  = '0;
    color_ball_nxt = '0;
    score_nxt      = '0;
    upd_dir        = dir_q;
    miss           = 1'b0;
    if (state_q == S_UPDATE) begin
      prev_ball_nxt  = curr_ball;
      color_ball_nxt = color_ball;
      score_nxt      = score;
      if (!dir_q) begin
        if (curr_ball != BOT_ROW) begin
          curr_ball_nxt = curr_ball + 8'd1;
        end else if (plat_color(lane) == color_ball) begin
          curr_ball_nxt  = BOT_ROW - 8'd1;
          upd_dir        = 1'b1;
          color_ball_nxt = lfsr_q;
          score_nxt      = (score == 12'hFFF) ? score : score + 12'd1;
        end else begin
          miss = 1'b1;
        end
      end else if (curr_ball <= TOP_ROW) begin
        curr_ball_nxt = curr_ball + 8'd1;
        upd_dir       = 1'b0;
      end else begin
        curr_ball_nxt = curr_ball - 8'd1;
      end
      mem_we = !miss;
    end
  end

  assign done_ok = draw_done && draw_req_q;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    plat_idx_d   = plat_idx_q;
    lfsr_d       = lfsr_q;
    overrun_d    = overrun_q;
    draw_req_d   = draw_req_q;
    draw_kind_d  = draw_kind_q;
    draw_pos_d   = draw_pos_q;
    draw_color_d = draw_color_q;
    if (frame_tick && busy_q) overrun_d = 1'b1;
    case (state_q)
      S_STOPPED, S_OVER: if (start) begin
        state_d   = S_IDLE;
        dir_d     = 1'b0;
        overrun_d = 1'b0;
      end
      S_IDLE: if (frame_tick) begin
        state_d      = S_ERASE;
        draw_req_d   = 1'b1;
        draw_kind_d  = 2'd0;
        draw_pos_d   = curr_ball;
        draw_color_d = 3'b000;
      end
      S_ERASE: if (done_ok) begin
        state_d    = S_UPDATE;
        draw_req_d = 1'b0;
      end
      S_UPDATE: begin
        lfsr_d  = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
        dir_d   = upd_dir;
        state_d = miss ? S_OVER : S_SETTLE;
      end
      S_SETTLE: begin
        state_d      = S_DRAW_BALL;
        draw_req_d   = 1'b1;
        draw_kind_d  = 2'd1;
        draw_pos_d   = curr_ball;
        draw_color_d = color_ball;
      end
      S_DRAW_BALL: if (done_ok) begin
        state_d      = S_DRAW_PLAT;
        plat_idx_d   = 2'd0;
        draw_kind_d  = 2'd2;
        draw_pos_d   = plat_pos(2'd0);
        draw_color_d = plat_color(2'd0);
      end
      // Requests run back to back: the next platform is presented in the
      // cycle right after the previous one completes.
      S_DRAW_PLAT: if (done_ok) begin
        if (plat_idx_q == 2'd3) begin
          state_d    = S_IDLE;
          draw_req_d = 1'b0;
        end else begin
          plat_idx_d   = plat_idx_q + 2'd1;
          draw_pos_d   = plat_pos(plat_idx_q + 2'd1);
          draw_color_d = plat_color(plat_idx_q + 2'd1);
        end
      end
      default: state_d = S_STOPPED;
    endcase
    busy_d      = !(state_d inside {S_STOPPED, S_IDLE, S_OVER});
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_STOPPED;
      dir_q        <= 1'b0;
      plat_idx_q   <= 2'd0;
      lfsr_q       <= 3'b001;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      draw_req_q   <= 1'b0;
      draw_kind_q  <= 2'd0;
      draw_pos_q   <= 8'd0;
      draw_color_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      plat_idx_q   <= plat_idx_d;
      lfsr_q       <= lfsr_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      draw_req_q   <= draw_req_d;
      draw_kind_q  <= draw_kind_d;
      draw_pos_q   <= draw_pos_d;
      draw_color_q <= draw_color_d;
    end
  end

  assign draw_req   = draw_req_q;
  assign draw_kind  = draw_kind_q;
  assign draw_pos   = draw_pos_q;
  assign draw_color = draw_color_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_bounce_frame_ctrl.sv
// Directed bench for bounce_frame_ctrl with a game-state memory model and an
// auto-responding drawer; expected values are hand-computed.
module tb_bounce_frame_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, frame_tick, draw_done;
  logic [1:0]  lane;
  logic [7:0]  curr_ball;
  logic [2:0]  color_ball;
  logic [11:0] color_plats, score;
  logic [27:0] position_plats;
  logic        mem_we, draw_req, busy, game_over, overrun;
  logic [7:0]  prev_ball_nxt, curr_ball_nxt, draw_pos;
  logic [2:0]  color_ball_nxt, draw_color;
  logic [11:0] score_nxt;
  logic [1:0]  draw_kind;

  int total = 0, bad = 0, cyc = 0;
  int e_done_cyc = 0, w_cyc = 0, b_cyc = -1;
  logic        ld, auto_en, man_done;
  logic [7:0]  ld_curr;
  logic [2:0]  ld_color;
  logic [11:0] ld_score;
  logic [12:0] dlog[$];
  logic [30:0] wlog[$];
  logic [12:0] exp_d[6];

  bounce_frame_ctrl #(.TOP(20), .BOTTOM(100)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .lane(lane),
    .draw_done(draw_done), .curr_ball(curr_ball), .color_ball(color_ball),
    .color_plats(color_plats), .position_plats(position_plats), .score(score),
    .mem_we(mem_we), .prev_ball_nxt(prev_ball_nxt), .curr_ball_nxt(curr_ball_nxt),
    .color_ball_nxt(color_ball_nxt), .score_nxt(score_nxt), .draw_req(draw_req),
    .draw_kind(draw_kind), .draw_pos(draw_pos), .draw_color(draw_color),
    .busy(busy), .game_over(game_over), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Game-state memory: bench loads override commits.
  always @(posedge clk) begin
    if (ld) begin
      curr_ball <= ld_curr; color_ball <= ld_color; score <= ld_score;
    end else if (mem_we) begin
      curr_ball <= curr_ball_nxt; color_ball <= color_ball_nxt; score <= score_nxt;
    end
  end

  // Drawer completes each request one cycle after it is presented.
  always @(posedge clk) draw_done <= auto_en ? (draw_req && !draw_done) : man_done;

  always @(negedge clk) begin
    if (!reset) begin
      if (draw_req && draw_done) begin
        dlog.push_back({draw_kind, draw_pos, draw_color});
        if (draw_kind == 2'd0) e_done_cyc = cyc;
      end
      if (mem_we) begin
        wlog.push_back({prev_ball_nxt, curr_ball_nxt, color_ball_nxt, score_nxt});
        w_cyc = cyc;
      end
      if (draw_req && draw_kind == 2'd1 && b_cyc < w_cyc) b_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] c, input logic [2:0] col, input logic [11:0] s);
    ld = 1'b1; ld_curr = c; ld_color = col; ld_score = s;
    step();
    ld = 1'b0;
  endtask

  task automatic run_frame(output int n);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    n = 0;
    while (busy && n < 60) begin n++; step(); end
    if (n >= 60) chk("frame_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    int n, k;
    auto_en = 1'b0; man_done = 1'b0; reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
    lane = 2'd0; ld = 1'b1; ld_curr = 8'd0; ld_color = 3'd5; ld_score = 12'd0;
    color_plats    = {3'd4, 3'd3, 3'd2, 3'd1};
    position_plats = {7'd40, 7'd30, 7'd20, 7'd10};
    exp_d[0] = {2'd0, 8'd0, 3'd0};  exp_d[1] = {2'd1, 8'd1, 3'd5};
    exp_d[2] = {2'd2, 8'd10, 3'd1}; exp_d[3] = {2'd2, 8'd20, 3'd2};
    exp_d[4] = {2'd2, 8'd30, 3'd3}; exp_d[5] = {2'd2, 8'd40, 3'd4};
    step(); step(); ld = 1'b0;
    chk("rst_outs", 64'({mem_we, prev_ball_nxt, curr_ball_nxt, color_ball_nxt, score_nxt,
                         draw_req, draw_kind, draw_pos, draw_color, game_over, overrun}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    reset = 1'b0; auto_en = 1'b1;
    start = 1'b1; frame_tick = 1'b1; step(); start = 1'b0; frame_tick = 1'b0;
    chk("start_wins", 64'({busy, overrun, game_over}), 64'd0);

    // First frame from row 0
    dlog.delete(); wlog.delete();
    run_frame(n);
    chk("frame_len", 64'(n), 64'd14);
    chk("f1_nreq", 64'(dlog.size()), 64'd6);
    for (int i = 0; i < dlog.size() && i < 6; i++) chk($sformatf("f1_req%0d", i), 64'(dlog[i]), 64'(exp_d[i]));
    chk("f1_nwe", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("f1_commit", 64'(wlog[0]), 64'({8'd0, 8'd1, 3'd5, 12'd0}));
    chk("we_lat", 64'(w_cyc - e_done_cyc), 64'd1);
    chk("ball_req_lat", 64'(b_cyc - w_cyc), 64'd2);

    // Landing hit on lane 2; lfsr has advanced once (010)
    load(8'd100, 3'd3, 12'd7); lane = 2'd2; wlog.delete();
    run_frame(n);
    chk("hit_nwe", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("hit_commit", 64'(wlog[0]), 64'({8'd100, 8'd99, 3'b010, 12'd8}));
    wlog.delete();
    run_frame(n);
    if (wlog.size() > 0) chk("up_move", 64'(wlog[0]), 64'({8'd99, 8'd98, 3'b010, 12'd8}));
    else chk("up_nwe", 64'(wlog.size()), 64'd1);

    // Reversal at TOP
    load(8'd20, 3'd2, 12'd8); wlog.delete();
    run_frame(n);
    if (wlog.size() > 0) chk("top_rev", 64'(wlog[0]), 64'({8'd20, 8'd21, 3'd2, 12'd8}));
    else chk("top_nwe", 64'(wlog.size()), 64'd1);

    // Saturating score hit, lfsr now 111
    load(8'd100, 3'd3, 12'hFFF); wlog.delete();
    run_frame(n);
    if (wlog.size() > 0) chk("sat_hit", 64'(wlog[0]), 64'({8'd100, 8'd99, 3'b111, 12'hFFF}));
    else chk("sat_nwe", 64'(wlog.size()), 64'd1);

    // Turn back down, then miss on lane 0
    load(8'd20, 3'd3, 12'd5);
    run_frame(n);
    chk("down_len", 64'(n), 64'd14);
    load(8'd100, 3'd3, 12'd5); lane = 2'd0; wlog.delete();
    run_frame(n);
    chk("miss_len", 64'(n), 64'd3);
    chk("miss_nwe", 64'(wlog.size()), 64'd0);
    chk("miss_over", 64'({busy, game_over, draw_req}), 64'b010);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    chk("over_tick", 64'({busy, draw_req, game_over, overrun}), 64'b0010);
    start = 1'b1; step(); start = 1'b0;
    chk("restart", 64'({busy, game_over, overrun}), 64'd0);

    // Tick during platform drawing
    load(8'd50, 3'd3, 12'd0); wlog.delete();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    k = 0;
    while (!(draw_req && draw_kind == 2'd2) && k < 30) begin k++; step(); end
    chk("reach_plat", 64'(k < 30), 64'd1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    k = 0;
    while (busy && k < 30) begin k++; step(); end
    chk("ovr_set", 64'({overrun, busy, game_over}), 64'b100);
    chk("ovr_nwe", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("ovr_commit", 64'(wlog[0][22:15]), 64'd51);

    // Reset during ERASE with a done arriving
    auto_en = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("erase_req", 64'({draw_req, draw_kind, busy}), 64'b1001);
    reset = 1'b1; man_done = 1'b1; step();
    chk("rst_mid", 64'({draw_req, mem_we, busy, overrun}), 64'd0);
    reset = 1'b0; step(); man_done = 1'b0;
    chk("rst_done_ign", 64'({draw_req, mem_we, busy}), 64'd0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    chk("stopped_tick", 64'({busy, draw_req, overrun}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
